// File: rtl/led_breathe.sv
// led_breathe: turns edges of a slow blink level into gradual PWM fades.
// A rising edge ramps the LED brightness up to MAX and a falling edge ramps it
// down to 0. Brightness moves one unit every STEP_DIV clocks. The LED pin is
// driven by a free-running PWM counter that is compared against the level.
module led_breathe #(
    parameter int PWM_BITS = 8,
    parameter int STEP_DIV = 65536
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                blink_in,
    output logic                led,
    output logic [PWM_BITS-1:0] level,
    output logic                busy
);

    localparam int SW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [PWM_BITS-1:0] MAX       = '1;
    localparam logic [SW-1:0]       STEP_LAST = SW'(STEP_DIV - 1);

    typedef enum logic [1:0] {
        S_OFF  = 2'd0,
        S_UP   = 2'd1,
        S_ON   = 2'd2,
        S_DOWN = 2'd3
    } state_t;

    state_t              state_q;
    logic [PWM_BITS-1:0] level_q;
    logic [PWM_BITS-1:0] pwm_cnt_q;
    logic [SW-1:0]       step_cnt_q;
    logic                blink_q;
    logic                led_q;
    logic                busy_q;

    logic                rise, fall, tick;
    logic [PWM_BITS-1:0] level_inc_d, level_dec_d;

    // Edge detect, step tick, and saturating neighbours of the current level.
    always_comb begin
        rise        = blink_in & ~blink_q;
        fall        = ~blink_in & blink_q;
        tick        = (step_cnt_q == STEP_LAST);
        level_inc_d = (level_q == MAX) ? MAX : level_q + 1'b1;
        level_dec_d = (level_q == '0) ? '0 : level_q - 1'b1;
    end

    // Fade FSM plus PWM generator; all outputs are registered here.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_OFF;
            level_q    <= '0;
            pwm_cnt_q  <= '0;
            step_cnt_q <= '0;
            blink_q    <= 1'b0;
            led_q      <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            blink_q   <= blink_in;
            pwm_cnt_q <= pwm_cnt_q + 1'b1;
            // Full level forces the LED solid on; otherwise compare against the ramp.
            led_q     <= (level_q == MAX) | (pwm_cnt_q < level_q);

            case (state_q)
                S_OFF: begin
                    step_cnt_q <= '0;
                    if (rise) begin
                        state_q <= S_UP;
                        busy_q  <= 1'b1;
                    end else begin
                        busy_q  <= 1'b0;
                    end
                end
                S_UP: begin
                    busy_q <= 1'b1;
                    if (fall) begin
                        // Reversal keeps the current level so there is no visible jump.
                        state_q    <= S_DOWN;
                        step_cnt_q <= '0;
                    end else if (tick) begin
                        step_cnt_q <= '0;
                        level_q    <= level_inc_d;
                        if (level_inc_d == MAX) begin
                            state_q <= S_ON;
                            busy_q  <= 1'b0;
                        end
                    end else begin
                        step_cnt_q <= step_cnt_q + 1'b1;
                    end
                end
                S_ON: begin
                    step_cnt_q <= '0;
                    if (fall) begin
                        state_q <= S_DOWN;
                        busy_q  <= 1'b1;
                    end else begin
                        busy_q  <= 1'b0;
                    end
                end
                default: begin // S_DOWN
                    busy_q <= 1'b1;
                    if (rise) begin
                        state_q    <= S_UP;
                        step_cnt_q <= '0;
                    end else if (tick) begin
                        step_cnt_q <= '0;
                        level_q    <= level_dec_d;
                        if (level_dec_d == '0) begin
                            state_q <= S_OFF;
                            busy_q  <= 1'b0;
                        end
                    end else begin
                        step_cnt_q <= step_cnt_q + 1'b1;
                    end
                end
            endcase
        end
    end

    assign led   = led_q;
    assign level = level_q;
    assign busy  = busy_q;

endmodule

// File: tb/tb_led_breathe.sv
// Directed bench for led_breathe with PWM_BITS=4, STEP_DIV=2 (MAX=15).
module tb_led_breathe;

    localparam int PB = 4;
    localparam int SD = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          blink_in;
    logic          led;
    logic [PB-1:0] level;
    logic          busy;

    int total = 0;
    int bad   = 0;

    led_breathe #(.PWM_BITS(PB), .STEP_DIV(SD)) dut (
        .clk      (clk),
        .reset    (reset),
        .blink_in (blink_in),
        .led      (led),
        .level    (level),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic    rst;
        logic    blink;
        int      n;
        int      exp_level;
        logic    exp_busy;
        logic    exp_led;
        logic    chk_led;
    } vec_t;

    vec_t vt[24];

    // One clock edge, then settle so outputs are sampled away from the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    initial begin
        int ones;
        // rst, blink, edges, level, busy, led, check-led
        vt[0]  = '{0, 0,  9,  0, 0, 0, 1};  // idle after release (e9)
        vt[1]  = '{0, 1,  1,  0, 1, 0, 1};  // rise at e10 -> busy
        vt[2]  = '{0, 1,  2,  1, 1, 0, 1};  // first step at e12
        vt[3]  = '{0, 1, 28, 15, 0, 0, 0};  // full at e40, ON
        vt[4]  = '{0, 0,  1, 15, 1, 1, 1};  // fall from ON (e71)
        vt[5]  = '{0, 0, 14,  8, 1, 0, 0};  // down to 8 (e85)
        vt[6]  = '{0, 1, 15, 15, 0, 0, 0};  // re-rise to full (e120)
        vt[7]  = '{0, 1,  5, 15, 0, 1, 1};  // ON held
        vt[8]  = '{0, 0, 31,  0, 0, 0, 0};  // full fade down
        vt[9]  = '{0, 0, 50,  0, 0, 0, 1};  // OFF held 50 edges
        vt[10] = '{0, 1, 15,  7, 1, 0, 0};  // up to 7
        vt[11] = '{1, 1,  1,  0, 0, 0, 1};  // reset mid-fade aborts
        vt[12] = '{1, 1,  3,  0, 0, 0, 1};  // reset held
        vt[13] = '{0, 1,  1,  0, 1, 0, 1};  // release with blink=1 -> rise
        vt[14] = '{0, 1, 10,  5, 1, 0, 0};  // UP at 5
        vt[15] = '{0, 0,  1,  5, 1, 0, 0};  // fall: level kept
        vt[16] = '{0, 0,  2,  4, 1, 0, 0};  // first down step
        vt[17] = '{0, 0,  8,  0, 0, 0, 0};  // reaches 0 -> OFF
        vt[18] = '{0, 0,  1,  0, 0, 0, 1};  // led off
        vt[19] = '{0, 1,  3,  1, 1, 0, 0};  // up to 1
        vt[20] = '{0, 0,  1,  1, 1, 0, 0};  // fall -> DOWN, step cleared
        vt[21] = '{0, 0,  1,  1, 1, 0, 0};  // one edge before tick
        vt[22] = '{0, 1,  1,  1, 1, 0, 0};  // rise on tick edge: no decrement
        vt[23] = '{0, 1,  2,  2, 1, 0, 0};  // step timer restarted by the reversal

        reset    = 1'b1;
        blink_in = 1'b0;

        // Held reset: everything quiet.
        for (int i = 0; i < 20; i++) begin
            step();
            chk("rst_led",   led,   0);
            chk("rst_level", level, 0);
            chk("rst_busy",  busy,  0);
        end

        for (int v = 0; v < 24; v++) begin
            reset    = vt[v].rst;
            blink_in = vt[v].blink;
            repeat (vt[v].n) step();
            chk($sformatf("v%0d_level", v), level, vt[v].exp_level);
            chk($sformatf("v%0d_busy", v),  busy,  vt[v].exp_busy);
            if (vt[v].chk_led)
                chk($sformatf("v%0d_led", v), led, vt[v].exp_led);

            if (v == 3) begin
                // Full brightness: LED solid on (e41..e70).
                for (int i = 0; i < 30; i++) begin
                    step();
                    chk("on_led", led, 1);
                end
            end

            if (v == 5) begin
                // Alternate blink every edge: each edge reverses, level pinned at 8.
                ones = 0;
                for (int i = 0; i < 20; i++) begin
                    blink_in = (i % 2 == 0);
                    step();
                    if (i >= 4) ones += led;
                end
                chk("duty8_ones",  ones,  8);
                chk("duty8_level", level, 8);
                chk("duty8_busy",  busy,  1);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Safety net: the stimulus is fixed-length, so this should never fire.
    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
